// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC transmit arbiter slice.
//   state_e           : arbiter FSM states (idle, frame transfer, gap)
//   IPG_BYTES_DEFAULT : default minimum inter-packet gap in bytes
//   len_width()       : width of a byte-count field for a given datapath
//   idx_width()       : width of a requester index (never below 1 bit)
//   ipg_cycles()      : gap length in beats, rounded up, never below 1
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_IPG  = 2'd2
    } state_e;

    localparam int IPG_BYTES_DEFAULT = 12;

    // A beat carries 1..DATA_W/8 bytes, so the count needs one bit more
    // than the index of the top byte.
    function automatic int len_width(input int data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The gap is counted in whole beats; a partial beat still costs a cycle.
    function automatic int ipg_cycles(input int ipg_bytes, input int bytes_per_beat);
        int c;
        c = (ipg_bytes + bytes_per_beat - 1) / bytes_per_beat;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin search. The search starts at the requester just
// above ptr_i and wraps, so the last winner has the lowest priority.
//   req_i       in  N_REQ  request vector
//   ptr_i       in  IDX_W  index of the previous winner
//   gnt_o       out IDX_W  index of the chosen requester
//   gnt_valid_o out 1      at least one request was present
// ---------------------------------------------------------------------------
module rr_arb
    import mac_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_o,
    output logic             gnt_valid_o
);

    // Walk N_REQ positions starting after the pointer and keep the first
    // hit; later hits are ignored once a winner is found.
    always_comb begin
        int idx;
        idx         = 0;
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_i) + i) % N_REQ;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o       = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mac_tx_arb.sv
// ---------------------------------------------------------------------------
// mac_tx_arb
// Round-robin frame arbiter in front of a MAC TX datapath. A requester wins
// only with a start beat; the winner then owns the output until its last beat
// is accepted, after which a fixed inter-packet gap is enforced.
//   clk, reset                      clock, synchronous active-high reset
//   req_valid_i/start_i/last_i      per-requester beat qualifiers
//   req_data_i, req_len_i           per-requester beat payload and byte count
//   req_ready_o                     per-requester beat accepted
//   ready_i                         MAC datapath can take a beat
//   valid_o/start_o/last_o          output beat qualifiers
//   data_o, len_o                   output beat payload and byte count
//   grant_o                         current/most recent owner
//   busy_o                          high while not idle
//   err_o                           one-cycle pulse on a repeated start beat
// ---------------------------------------------------------------------------
module mac_tx_arb
    import mac_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int N_REQ     = 2,
    parameter  int IPG_BYTES = IPG_BYTES_DEFAULT,
    localparam int LEN_W     = len_width(DATA_W),
    localparam int GNT_W     = idx_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_start_i,
    input  logic [N_REQ-1:0]        req_last_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic                    start_o,
    output logic                    last_o,
    output logic [DATA_W-1:0]       data_o,
    output logic [LEN_W-1:0]        len_o,
    output logic [GNT_W-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int DATA_BYTES_N = DATA_W / 8;
    localparam int IPG_CYC      = ipg_cycles(IPG_BYTES, DATA_BYTES_N);
    localparam int CNT_W        = $clog2(IPG_CYC + 1);

    state_e           state_q, state_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] start_req;
    logic [GNT_W-1:0] arb_gnt;
    logic             arb_valid;
    logic             beat_xfer;

    // Only a valid start beat makes a requester eligible; a stray mid-frame
    // beat presented while idle is ignored.
    assign start_req = req_valid_i & req_start_i;

    rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (GNT_W)
    ) u_rr_arb (
        .req_i       (start_req),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .gnt_valid_o (arb_valid)
    );

    // Output mux: during a transfer the owner's beat passes straight through
    // and only the owner sees ready; outside a transfer nothing is offered.
    always_comb begin
        valid_o     = 1'b0;
        start_o     = 1'b0;
        last_o      = 1'b0;
        data_o      = '0;
        len_o       = '0;
        req_ready_o = '0;
        beat_xfer   = 1'b0;
        if (state_q == ST_XFER) begin
            valid_o              = req_valid_i[grant_q];
            start_o              = req_start_i[grant_q];
            last_o               = req_last_i[grant_q];
            data_o               = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
            len_o                = req_len_i[int'(grant_q)*LEN_W +: LEN_W];
            req_ready_o[grant_q] = ready_i;
            beat_xfer            = req_valid_i[grant_q] & ready_i;
        end
    end

    // Next-state logic. The grant is taken one cycle ahead of the first beat.
    // A start beat after the frame's first accepted beat is still forwarded
    // but flagged. The gap counter is loaded on the last beat and the FSM
    // returns to idle in the cycle the count reads one.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_gnt;
                    rr_ptr_d = arb_gnt;
                    first_d  = 1'b1;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_xfer) begin
                    first_d = 1'b0;
                    if (start_o && !first_q) begin
                        err_d = 1'b1;
                    end
                    if (last_o) begin
                        cnt_d   = CNT_W'(IPG_CYC);
                        state_d = ST_IPG;
                    end
                end
            end
            ST_IPG: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset points the round-robin pointer at the top
    // requester so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GNT_W'(N_REQ - 1);
            cnt_q    <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_mac_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_arb
// Requesters are frame queues driven by the bench. A cycle-timed reference
// model built from the arbitration rules (round-robin among start beats,
// owner holds until its last beat, idle again 7 cycles after that beat)
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mac_tx_arb;

    localparam int DATA_W     = 16;
    localparam int N_REQ      = 2;
    localparam int LEN_W      = 2;
    localparam int FULL_LEN   = DATA_W / 8;
    localparam int GAP_CYCLES = 6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic              start;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic              valid;
        logic              start;
        logic              last;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [N_REQ-1:0]  rr;
        logic              busy;
        logic              grant;
        logic              err;
    } sig_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_start_i;
    logic [N_REQ-1:0]        req_last_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ*LEN_W-1:0]  req_len_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic                    ready_i;
    logic                    valid_o;
    logic                    start_o;
    logic                    last_o;
    logic [DATA_W-1:0]       data_o;
    logic [LEN_W-1:0]        len_o;
    logic                    grant_o;
    logic                    busy_o;
    logic                    err_o;

    mac_tx_arb #(
        .DATA_W    (DATA_W),
        .N_REQ     (N_REQ),
        .IPG_BYTES (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_start_i (req_start_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_len_i   (req_len_i),
        .req_ready_o (req_ready_o),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .start_o     (start_o),
        .last_o      (last_o),
        .data_o      (data_o),
        .len_o       (len_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int err_seen = 0;

    beat_t src_q [N_REQ][$];
    bit    ready_plan[$];
    bit    rand_ready = 1'b0;
    bit    bubbles    = 1'b0;

    sig_t  obs_q[$];
    sig_t  exp_q[$];
    int    cyc_q[$];

    int                ob_cyc[$];
    int                ob_gnt[$];
    bit                ob_start[$];
    bit                ob_last[$];
    logic [DATA_W-1:0] ob_data[$];

    bit m_xfer;
    int m_owner;
    int m_last;
    int m_grant;
    int m_arb_ok;
    bit m_first;
    bit m_err;

    // Reference model reset: idle, requester 0 searched first.
    function automatic void model_reset();
        m_xfer   = 1'b0;
        m_owner  = 0;
        m_last   = N_REQ - 1;
        m_grant  = 0;
        m_arb_ok = 0;
        m_first  = 1'b0;
        m_err    = 1'b0;
    endfunction

    // Queue a frame on requester k; bad_beat >= 1 marks that beat as start too.
    function automatic void push_frame(input int k, input int nbeats, input int bad_beat);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data  = DATA_W'($urandom);
            b.start = (i == 0) || (i == bad_beat);
            b.last  = (i == nbeats - 1);
            b.len   = b.last ? LEN_W'($urandom_range(1, FULL_LEN)) : LEN_W'(FULL_LEN);
            src_q[k].push_back(b);
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample 1 ns later,
    // log observed vs predicted outputs, then advance the model.
    task automatic step(input bit do_reset);
        logic [N_REQ-1:0] dv;
        beat_t            hb;
        sig_t             e;
        sig_t             o;
        int               k;
        bit               picked;
        @(negedge clk);
        reset = do_reset;
        if (ready_plan.size() > 0) ready_i = ready_plan.pop_front();
        else if (rand_ready)       ready_i = ($urandom_range(0, 3) != 0);
        else                       ready_i = 1'b1;
        for (int r = 0; r < N_REQ; r++) begin
            if (src_q[r].size() > 0 && !(bubbles && $urandom_range(0, 4) == 0)) begin
                dv[r] = 1'b1;
                hb    = src_q[r][0];
            end else begin
                dv[r]    = 1'b0;
                hb.data  = DATA_W'($urandom);
                hb.len   = LEN_W'($urandom);
                hb.start = 1'($urandom);
                hb.last  = 1'($urandom);
            end
            req_valid_i[r]                = dv[r];
            req_start_i[r]                = hb.start;
            req_last_i[r]                 = hb.last;
            req_data_i[r*DATA_W +: DATA_W] = hb.data;
            req_len_i[r*LEN_W +: LEN_W]   = hb.len;
        end
        #1;
        e       = '0;
        e.busy  = m_xfer || (cyc < m_arb_ok);
        e.grant = 1'(m_grant);
        e.err   = m_err;
        if (m_xfer) begin
            e.valid        = dv[m_owner];
            e.rr[m_owner]  = ready_i;
            if (e.valid) begin
                hb      = src_q[m_owner][0];
                e.start = hb.start;
                e.last  = hb.last;
                e.data  = hb.data;
                e.len   = hb.len;
            end
        end
        o       = '0;
        o.valid = valid_o;
        o.rr    = req_ready_o;
        o.busy  = busy_o;
        o.grant = grant_o;
        o.err   = err_o;
        if (e.valid) begin
            o.start = start_o;
            o.last  = last_o;
            o.data  = data_o;
            o.len   = len_o;
        end
        obs_q.push_back(o);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            ob_cyc.push_back(cyc);
            ob_gnt.push_back(int'(grant_o));
            ob_start.push_back(start_o);
            ob_last.push_back(last_o);
            ob_data.push_back(data_o);
        end
        if (err_o === 1'b1) err_seen++;

        m_err = 1'b0;
        if (do_reset) begin
            model_reset();
        end else if (m_xfer) begin
            if (dv[m_owner] && ready_i) begin
                hb = src_q[m_owner].pop_front();
                if (hb.start && !m_first) m_err = 1'b1;
                m_first = 1'b0;
                if (hb.last) begin
                    m_xfer   = 1'b0;
                    m_arb_ok = cyc + GAP_CYCLES + 1;
                end
            end
        end else if (cyc >= m_arb_ok) begin
            picked = 1'b0;
            for (int i = 1; i <= N_REQ; i++) begin
                k = (m_last + i) % N_REQ;
                if (!picked && dv[k] && src_q[k][0].start) begin
                    picked  = 1'b1;
                    m_owner = k;
                    m_last  = k;
                    m_grant = k;
                    m_xfer  = 1'b1;
                    m_first = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || m_xfer || cyc < m_arb_ok)
               && n < budget) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("[TB] FAIL %s_timeout cycles=%0d budget=%0d", name, n, budget);
        end
    endtask

    task automatic test_reset();
        int s;
        s = obs_q.size();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        checks += 5;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", valid_o); end
        if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy_o); end
        if (grant_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant got=%b want=0", grant_o); end
        if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err_o); end
        if (req_ready_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_rdy got=%b want=00", req_ready_o); end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL reset_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_single_frame();
        int s, b;
        s = obs_q.size();
        b = ob_cyc.size();
        push_frame(0, 4, -1);
        run_until_idle(100, "single");
        checks++;
        if (ob_cyc.size() - b != 4) begin
            failures++;
            $display("[TB] FAIL single_beats got=%0d want=4", ob_cyc.size() - b);
        end else begin
            checks += 3;
            if (ob_start[b] !== 1'b1) begin failures++; $display("[TB] FAIL single_start got=%b want=1", ob_start[b]); end
            if (ob_last[b+3] !== 1'b1) begin failures++; $display("[TB] FAIL single_last got=%b want=1", ob_last[b+3]); end
            if (ob_gnt[b] != 0 || ob_gnt[b+3] != 0) begin
                failures++;
                $display("[TB] FAIL single_grant got=%0d/%0d want=0", ob_gnt[b], ob_gnt[b+3]);
            end
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL single_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int s, b;
        step(1'b1);
        s = obs_q.size();
        b = ob_cyc.size();
        push_frame(0, 3, -1);
        push_frame(1, 3, -1);
        run_until_idle(200, "simul");
        checks++;
        if (ob_cyc.size() - b != 6) begin
            failures++;
            $display("[TB] FAIL simul_beats got=%0d want=6", ob_cyc.size() - b);
        end else begin
            checks += 3;
            if (ob_gnt[b] != 0) begin failures++; $display("[TB] FAIL simul_first_owner got=%0d want=0", ob_gnt[b]); end
            if (ob_gnt[b+3] != 1) begin failures++; $display("[TB] FAIL simul_second_owner got=%0d want=1", ob_gnt[b+3]); end
            if (ob_cyc[b+3] - ob_cyc[b+2] != 8) begin
                failures++;
                $display("[TB] FAIL simul_gap got=%0d want=8", ob_cyc[b+3] - ob_cyc[b+2]);
            end
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL simul_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int    s, b;
        beat_t frame[$];
        step(1'b1);
        s = obs_q.size();
        b = ob_cyc.size();
        push_frame(0, 5, -1);
        frame = src_q[0];
        ready_plan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_until_idle(200, "bp");
        checks++;
        if (ob_cyc.size() - b != 5) begin
            failures++;
            $display("[TB] FAIL bp_beats got=%0d want=5", ob_cyc.size() - b);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ob_data[b+i] !== frame[i].data) begin
                    failures++;
                    $display("[TB] FAIL bp_data beat=%0d got=%h want=%h", i, ob_data[b+i], frame[i].data);
                end
            end
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL bp_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alternate();
        int s, b, n;
        int want[4];
        want = '{0, 1, 0, 1};
        step(1'b1);
        s = obs_q.size();
        b = ob_cyc.size();
        push_frame(1, 2, -1);
        push_frame(1, 2, -1);
        push_frame(0, 2, -1);
        push_frame(0, 2, -1);
        run_until_idle(300, "alt");
        n = 0;
        for (int i = b; i < ob_cyc.size(); i++) begin
            if (ob_start[i] && n < 4) begin
                checks++;
                if (ob_gnt[i] != want[n]) begin
                    failures++;
                    $display("[TB] FAIL alt_grant frame=%0d got=%0d want=%0d", n, ob_gnt[i], want[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin failures++; $display("[TB] FAIL alt_frames got=%0d want=4", n); end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL alt_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_error();
        int s, b, e0;
        s  = obs_q.size();
        b  = ob_cyc.size();
        e0 = err_seen;
        push_frame(1, 3, 1);
        run_until_idle(100, "err");
        checks++;
        if (err_seen - e0 != 1) begin
            failures++;
            $display("[TB] FAIL err_pulses got=%0d want=1", err_seen - e0);
        end
        checks++;
        if (ob_cyc.size() - b != 3) begin
            failures++;
            $display("[TB] FAIL err_beats got=%0d want=3", ob_cyc.size() - b);
        end else begin
            checks++;
            if (ob_start[b+1] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL err_forward got=%b want=1", ob_start[b+1]);
            end
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL err_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int s, b;
        step(1'b1);
        s = obs_q.size();
        push_frame(0, 4, -1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        src_q[0].delete();
        step(1'b0);
        checks += 2;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b want=0", valid_o); end
        if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy_o); end
        b = ob_cyc.size();
        push_frame(1, 3, -1);
        run_until_idle(100, "rstmid");
        checks++;
        if (ob_cyc.size() - b != 3) begin
            failures++;
            $display("[TB] FAIL rstmid_beats got=%0d want=3", ob_cyc.size() - b);
        end else begin
            checks++;
            if (ob_gnt[b] != 1 || ob_start[b] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rstmid_grant got=%0d start=%b want=1 start=1", ob_gnt[b], ob_start[b]);
            end
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL rstmid_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_no_start();
        int    s, b;
        beat_t stray;
        s = obs_q.size();
        b = ob_cyc.size();
        stray.data  = DATA_W'($urandom);
        stray.len   = LEN_W'(FULL_LEN);
        stray.start = 1'b0;
        stray.last  = 1'b0;
        src_q[1].push_back(stray);
        repeat (5) step(1'b0);
        checks += 2;
        if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL nostart_busy got=%b want=0", busy_o); end
        if (ob_cyc.size() != b) begin
            failures++;
            $display("[TB] FAIL nostart_beats got=%0d want=0", ob_cyc.size() - b);
        end
        src_q[1].delete();
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL nostart_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int s, b, pushed, n, bad;
        s      = obs_q.size();
        b      = ob_cyc.size();
        pushed = 0;
        rand_ready = 1'b1;
        bubbles    = 1'b1;
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    n   = $urandom_range(1, 5);
                    bad = (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
                    push_frame(k, n, bad);
                    pushed += n;
                end
            end
            step(1'b0);
        end
        run_until_idle(3000, "rand");
        rand_ready = 1'b0;
        bubbles    = 1'b0;
        checks++;
        if (ob_cyc.size() - b != pushed) begin
            failures++;
            $display("[TB] FAIL rand_beats got=%0d want=%0d", ob_cyc.size() - b, pushed);
        end
        for (int i = s; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL rand_cycle cyc=%0d got=%h want=%h", cyc_q[i], obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        ready_i     = 1'b1;
        req_valid_i = '0;
        req_start_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        req_len_i   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        $display("[TB] starting mac_tx_arb bench");
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_backpressure();
        test_alternate();
        test_start_error();
        test_reset_midframe();
        test_no_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
